// File: rtl/serial_divu.sv
// Multi-cycle unsigned radix-2 restoring divider with stream handshakes.
// Result is {quotient, remainder}; divide-by-zero is flagged on tuser and short-circuited.
module serial_divu #(
   parameter int WIDTH = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               s_axis_dividend_tvalid,
   output logic               s_axis_dividend_tready,
   input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
   input  logic               s_axis_divisor_tvalid,
   output logic               s_axis_divisor_tready,
   input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
   output logic               m_axis_dout_tvalid,
   input  logic               m_axis_dout_tready,
   output logic [2*WIDTH-1:0] m_axis_dout_tdata,
   output logic               m_axis_dout_tuser,
   output logic               busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [WIDTH:0]     r_q, r_d;
   logic [WIDTH-1:0]   dsr_q, dsr_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] tdata_q, tdata_d;
   logic               tuser_q, tuser_d;

   logic               s_tready, accept, ge;
   logic [WIDTH:0]     r_sh, r_nx;
   logic [WIDTH-1:0]   q_nx;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      r_sh = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
      ge   = (r_sh >= {1'b0, dsr_q});
      r_nx = ge ? (r_sh - {1'b0, dsr_q}) : r_sh;
      q_nx = {q_q[WIDTH-2:0], ge};
   end

   assign s_tready = (state_q == IDLE) | ((state_q == DONE) & m_axis_dout_tready);
   assign accept   = s_tready & s_axis_dividend_tvalid & s_axis_divisor_tvalid;

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      r_d     = r_q;
      dsr_d   = dsr_q;
      cnt_d   = cnt_q;
      tdata_d = tdata_q;
      tuser_d = tuser_q;
      // Accept covers both the idle start and the overlapped restart from DONE.
      if (accept) begin
         if (s_axis_divisor_tdata == '0) begin
            state_d = DONE;
            tdata_d = {{WIDTH{1'b1}}, s_axis_dividend_tdata};
            tuser_d = 1'b1;
         end else begin
            state_d = RUN;
            q_d     = s_axis_dividend_tdata;
            dsr_d   = s_axis_divisor_tdata;
            r_d     = '0;
            cnt_d   = '0;
         end
      end else begin
         case (state_q)
            RUN: begin
               q_d   = q_nx;
               r_d   = r_nx;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH-1)) begin
                  tdata_d = {q_nx, r_nx[WIDTH-1:0]};
                  tuser_d = 1'b0;
                  state_d = DONE;
               end
            end
            DONE: if (m_axis_dout_tready) state_d = IDLE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         q_q     <= '0;
         r_q     <= '0;
         dsr_q   <= '0;
         cnt_q   <= '0;
         tdata_q <= '0;
         tuser_q <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dsr_q   <= dsr_d;
         cnt_q   <= cnt_d;
         tdata_q <= tdata_d;
         tuser_q <= tuser_d;
      end
   end

   assign s_axis_dividend_tready = s_tready;
   assign s_axis_divisor_tready  = s_tready;
   assign m_axis_dout_tvalid     = (state_q == DONE);
   assign m_axis_dout_tdata      = tdata_q;
   assign m_axis_dout_tuser      = tuser_q;
   assign busy                   = (state_q != IDLE);

endmodule

// File: tb/tb_serial_divu.sv
// Directed-vector bench for serial_divu: latency, results, backpressure, overlap, reset abort.
module tb_serial_divu;

   localparam int W = 32;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic           dvd_v = 1'b0, dsr_v = 1'b0;
   logic [W-1:0]   dvd_d = '0, dsr_d = '0;
   logic           dvd_r, dsr_r;
   logic           o_v, o_r = 1'b1, o_u, bsy;
   logic [2*W-1:0] o_d;

   int nvec = 0;
   int nerr = 0;
   int cyc;

   always #5 clock = ~clock;

   serial_divu #(.WIDTH(W)) dut (
      .clock                  (clock),
      .reset                  (reset),
      .s_axis_dividend_tvalid (dvd_v),
      .s_axis_dividend_tready (dvd_r),
      .s_axis_dividend_tdata  (dvd_d),
      .s_axis_divisor_tvalid  (dsr_v),
      .s_axis_divisor_tready  (dsr_r),
      .s_axis_divisor_tdata   (dsr_d),
      .m_axis_dout_tvalid     (o_v),
      .m_axis_dout_tready     (o_r),
      .m_axis_dout_tdata      (o_d),
      .m_axis_dout_tuser      (o_u),
      .busy                   (bsy)
   );

   task automatic chk(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present both operands for exactly one edge; returns #1 after that edge.
   task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
      dvd_v = 1'b1; dsr_v = 1'b1; dvd_d = a; dsr_d = b;
      @(posedge clock); #1;
      dvd_v = 1'b0; dsr_v = 1'b0;
   endtask

   // Counts edges until tvalid is seen, bounded.
   task automatic wait_result(output int n);
      n = 0;
      while (!o_v && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
   endtask

   typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [2*W-1:0] r; } vec_t;
   vec_t vecs[3];

   initial begin
      int seen;
      logic [2*W-1:0] held;
      vecs[0] = '{32'hFFFF_FFFF, 32'h1,         64'hFFFFFFFF_00000000};
      vecs[1] = '{32'd3,         32'd10,        64'h00000000_00000003};
      vecs[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000};

      // Reset state
      #12;
      chk("rst_tvalid", 64'(o_v), 64'd0);
      chk("rst_tdata",  o_d, 64'd0);
      chk("rst_tuser",  64'(o_u), 64'd0);
      chk("rst_busy",   64'(bsy), 64'd0);
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock); #1;
      chk("idle_tready", 64'({dvd_r, dsr_r}), 64'd3);

      // Basic 100/7
      start(100, 7);
      chk("run_busy", 64'(bsy), 64'd1);
      wait_result(cyc);
      chk("basic_lat",   64'(cyc), 64'd32);
      chk("basic_tdata", o_d, 64'h0000000E_00000002);
      chk("basic_tuser", 64'(o_u), 64'd0);
      @(posedge clock); #1;
      chk("basic_vdrop", 64'(o_v), 64'd0);
      chk("basic_idle",  64'(bsy), 64'd0);

      // Boundary operands
      foreach (vecs[i]) begin
         start(vecs[i].a, vecs[i].b);
         wait_result(cyc);
         chk($sformatf("edge%0d_lat", i),   64'(cyc), 64'd32);
         chk($sformatf("edge%0d_tdata", i), o_d, vecs[i].r);
         chk($sformatf("edge%0d_tuser", i), 64'(o_u), 64'd0);
         @(posedge clock); #1;
      end

      // Divide by zero: result visible the cycle after accept
      start(5, 0);
      wait_result(cyc);
      chk("dz_lat",   64'(cyc), 64'd0);
      chk("dz_tvalid", 64'(o_v), 64'd1);
      chk("dz_tdata", o_d, 64'hFFFFFFFF_00000005);
      chk("dz_tuser", 64'(o_u), 64'd1);
      @(posedge clock); #1;
      chk("dz_vdrop", 64'(o_v), 64'd0);

      // Backpressure: result held, inputs refused
      o_r = 1'b0;
      start(100, 7);
      wait_result(cyc);
      chk("bp_lat", 64'(cyc), 64'd32);
      held = o_d;
      dvd_v = 1'b1; dsr_v = 1'b1; dvd_d = 50; dsr_d = 6;
      for (int k = 0; k < 10; k++) begin
         @(posedge clock); #1;
         chk("bp_tdata",  o_d, 64'h0000000E_00000002);
         chk("bp_held",   o_d, held);
         chk("bp_tvalid", 64'(o_v), 64'd1);
         chk("bp_sready", 64'(dvd_r | dsr_r), 64'd0);
      end
      dvd_v = 1'b0; dsr_v = 1'b0; o_r = 1'b1;
      @(posedge clock); #1;
      chk("bp_release", 64'({o_v, bsy}), 64'd0);

      // Only dividend valid: no accept
      dvd_v = 1'b1; dvd_d = 9; dsr_d = 3;
      repeat (3) begin
         @(posedge clock); #1;
         chk("half_busy", 64'({o_v, bsy}), 64'd0);
      end
      dvd_v = 1'b0;

      // Back-to-back with overlap in DONE
      start(100, 7);
      wait_result(cyc);
      chk("b2b_first", o_d, 64'h0000000E_00000002);
      start(50, 6);
      chk("b2b_vdrop", 64'({o_v, bsy}), 64'd1);
      wait_result(cyc);
      chk("b2b_lat",   64'(cyc), 64'd32);
      chk("b2b_tdata", o_d, 64'h00000008_00000002);
      // Overlapped restart into divide-by-zero keeps tvalid high
      start(7, 0);
      chk("b2b_dz_v",    64'(o_v), 64'd1);
      chk("b2b_dz_data", o_d, 64'hFFFFFFFF_00000007);
      chk("b2b_dz_user", 64'(o_u), 64'd1);
      @(posedge clock); #1;
      chk("b2b_dz_done", 64'({o_v, bsy}), 64'd0);

      // Reset mid-operation
      start(100, 7);
      repeat (15) @(posedge clock);
      #1 reset = 1'b0;
      #1;
      chk("mrst_state", 64'({o_v, bsy}), 64'd0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clock); #1;
         if (o_v) seen = 1;
      end
      chk("mrst_novalid", 64'(seen), 64'd0);
      chk("mrst_idle",    64'(bsy), 64'd0);
      chk("mrst_sready",  64'(dvd_r & dsr_r), 64'd1);
      start(9, 3);
      wait_result(cyc);
      chk("mrst_lat",   64'(cyc), 64'd32);
      chk("mrst_tdata", o_d, 64'h00000003_00000000);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
